// File: rtl/traffic_controller_timed.sv
// Timed highway/country light controller: dwell timers, latched country request,
// min/max green and all-red clearance. Optional pedestrian crossing under PED_XING_EN.
module traffic_controller_timed #(
    parameter int unsigned CNT_W         = 8,
    parameter int unsigned HWY_MIN_GREEN = 20,
    parameter int unsigned HWY_YELLOW    = 4,
    parameter int unsigned ALL_RED       = 2,
    parameter int unsigned CTY_MIN_GREEN = 3,
    parameter int unsigned CTY_MAX_GREEN = 15,
    parameter int unsigned CTY_YELLOW    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       x,
`ifdef PED_XING_EN
    input  logic       ped_req,
    output logic       walk,
`endif
    output logic [2:0] highway,
    output logic [2:0] country,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        S_HG  = 3'd0,
        S_HY  = 3'd1,
        S_AR1 = 3'd2,
        S_CG  = 3'd3,
        S_CY  = 3'd4,
        S_AR2 = 3'd5
    } state_e;

    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_GREEN  = 3'b001;

    localparam logic [CNT_W-1:0] HG_MIN_C = CNT_W'(HWY_MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] HY_END_C = CNT_W'(HWY_YELLOW - 1);
    localparam logic [CNT_W-1:0] AR_END_C = CNT_W'(ALL_RED - 1);
    localparam logic [CNT_W-1:0] CG_MIN_C = CNT_W'(CTY_MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] CG_MAX_C = CNT_W'(CTY_MAX_GREEN - 1);
    localparam logic [CNT_W-1:0] CY_END_C = CNT_W'(CTY_YELLOW - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             req_pend_q, req_pend_d;
    logic [2:0]       highway_q, highway_d;
    logic [2:0]       country_q, country_d;
    logic [2:0]       phase_q, phase_d;

    logic             ped_c;
    logic             cg_hold_c;
    logic             cg_entry_c;

`ifdef PED_XING_EN
    logic ped_pend_q, ped_pend_d;
    logic walk_q, walk_d;

    assign ped_c     = ped_pend_q | ped_req;
    assign cg_hold_c = walk_q;
    assign walk      = walk_q;

    // Pedestrian latch; a served request holds CG to its maximum with walk lit.
    always_comb begin
        ped_pend_d = ped_pend_q;
        walk_d     = walk_q;
        if (start) begin
            if (ped_req) begin
                ped_pend_d = 1'b1;
            end
            if (cg_entry_c) begin
                walk_d     = ped_c;
                ped_pend_d = 1'b0;
            end else if (state_d != S_CG) begin
                walk_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ped_pend_q <= 1'b0;
            walk_q     <= 1'b0;
        end else begin
            ped_pend_q <= ped_pend_d;
            walk_q     <= walk_d;
        end
    end
`else
    assign ped_c     = 1'b0;
    assign cg_hold_c = 1'b0;
`endif

    assign cg_entry_c = (state_d == S_CG) && (state_q != S_CG);

    // Next state, dwell counter and request latch; everything holds while start=0.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_pend_d = req_pend_q;
        if (start) begin
            case (state_q)
                S_HG:  if ((cnt_q >= HG_MIN_C) && (req_pend_q || x || ped_c)) state_d = S_HY;
                S_HY:  if (cnt_q == HY_END_C) state_d = S_AR1;
                S_AR1: if (cnt_q == AR_END_C) state_d = S_CG;
                S_CG: begin
                    if (cnt_q == CG_MAX_C) begin
                        state_d = S_CY;
                    end else if (!cg_hold_c && (cnt_q >= CG_MIN_C) && !x) begin
                        state_d = S_CY;
                    end
                end
                S_CY:  if (cnt_q == CY_END_C) state_d = S_AR2;
                S_AR2: if (cnt_q == AR_END_C) state_d = S_HG;
                default: state_d = S_HG;
            endcase

            if (x && ((state_q == S_HG) || (state_q == S_HY) || (state_q == S_AR1))) begin
                req_pend_d = 1'b1;
            end
            if (cg_entry_c) begin
                req_pend_d = 1'b0;
            end

            if (state_d != state_q) begin
                cnt_d = '0;
            end else if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Lamps decoded from next state so they change on the same edge as phase.
    always_comb begin
        highway_d = LAMP_RED;
        country_d = LAMP_RED;
        phase_d   = state_d;
        case (state_d)
            S_HG: highway_d = LAMP_GREEN;
            S_HY: highway_d = LAMP_YELLOW;
            S_CG: country_d = LAMP_GREEN;
            S_CY: country_d = LAMP_YELLOW;
            default: begin
                highway_d = LAMP_RED;
                country_d = LAMP_RED;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_HG;
            cnt_q      <= '0;
            req_pend_q <= 1'b0;
            highway_q  <= LAMP_GREEN;
            country_q  <= LAMP_RED;
            phase_q    <= 3'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            req_pend_q <= req_pend_d;
            highway_q  <= highway_d;
            country_q  <= country_d;
            phase_q    <= phase_d;
        end
    end

    assign highway = highway_q;
    assign country = country_q;
    assign phase   = phase_q;

endmodule

// File: tb/tb_traffic_controller_timed.sv
// Scoreboard bench for traffic_controller_timed: stimulus pushes reference-model
// expectations, a monitor pops and compares after every clock edge.
module tb_traffic_controller_timed;

    localparam int HMG = 20;
    localparam int HY  = 4;
    localparam int AR  = 2;
    localparam int CMN = 3;
    localparam int CMX = 15;
    localparam int CY  = 4;

    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] GREEN  = 3'b001;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start = 1'b0;
    logic       x = 1'b0;
    logic       ped_req = 1'b0;
    logic       walk_w;
    logic [2:0] highway, country, phase;

    traffic_controller_timed #(
        .CNT_W(8), .HWY_MIN_GREEN(HMG), .HWY_YELLOW(HY), .ALL_RED(AR),
        .CTY_MIN_GREEN(CMN), .CTY_MAX_GREEN(CMX), .CTY_YELLOW(CY)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .x       (x),
`ifdef PED_XING_EN
        .ped_req (ped_req),
        .walk    (walk_w),
`endif
        .highway (highway),
        .country (country),
        .phase   (phase)
    );

`ifndef PED_XING_EN
    assign walk_w = 1'b0;
`endif

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] ph;
        logic [2:0] hw;
        logic [2:0] cty;
        logic       walk;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;

    // Reference model: phase index, enabled cycles already spent in it, latches.
    int m_ph = 0;
    int m_t = 0;
    bit m_req = 0;
    bit m_ped = 0;
    bit m_walk = 0;

    function automatic void check(string nm, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic logic [2:0] hw_of(int ph);
        if (ph == 0) return GREEN;
        if (ph == 1) return YELLOW;
        return RED;
    endfunction

    function automatic logic [2:0] cty_of(int ph);
        if (ph == 3) return GREEN;
        if (ph == 4) return YELLOW;
        return RED;
    endfunction

    task automatic model_reset();
        m_ph = 0; m_t = 0; m_req = 0; m_ped = 0; m_walk = 0;
    endtask

    task automatic model_edge(bit rs, bit st, bit xv, bit pr);
        int n;
        bit done;
        if (!rs) begin
            model_reset();
            return;
        end
        if (!st) return;
        n = m_t + 1;
        case (m_ph)
            0: done = (n >= HMG) && (m_req || xv || m_ped || pr);
            1: done = (n == HY);
            2: done = (n == AR);
            3: done = m_walk ? (n == CMX) : ((n == CMX) || (n >= CMN && !xv));
            4: done = (n == CY);
            default: done = (n == AR);
        endcase
        if (m_ph <= 2 && xv) m_req = 1;
        if (pr) m_ped = 1;
        if (done) begin
            m_ph = (m_ph + 1) % 6;
            m_t  = 0;
            if (m_ph == 3) begin
                m_req  = 0;
                m_walk = m_ped;
                m_ped  = 0;
            end else begin
                m_walk = 0;
            end
        end else begin
            m_t = n;
        end
    endtask

    task automatic step(bit rs, bit st, bit xv, bit pr);
        exp_t e;
        @(negedge clk);
        rst_n = rs;
        start = st;
        x     = xv;
`ifdef PED_XING_EN
        ped_req = pr;
`else
        ped_req = 1'b0;
        pr = 1'b0;
`endif
        model_edge(rs, st, xv, pr);
        e.ph   = 3'(m_ph);
        e.hw   = hw_of(m_ph);
        e.cty  = cty_of(m_ph);
        e.walk = m_walk;
        q.push_back(e);
    endtask

    // Asynchronous reset between edges; outputs must snap to reset values at once.
    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_phase", int'(phase), 0);
        check("async_rst_highway", int'(highway), int'(GREEN));
        check("async_rst_country", int'(country), int'(RED));
        check("async_rst_walk", int'(walk_w), 0);
        model_reset();
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        step(1, 1, 0, 0);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            check("phase", int'(phase), int'(e.ph));
            check("highway", int'(highway), int'(e.hw));
            check("country", int'(country), int'(e.cty));
            check("safety", int'(highway != RED && country != RED), 0);
`ifdef PED_XING_EN
            check("walk", int'(walk_w), int'(e.walk));
`endif
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit xr;
        rst_n = 1'b1;
        do_reset();

        // No country traffic: highway green holds indefinitely.
        repeat (100) step(1, 1, 0, 0);

        // Continuous demand: full cycle with CG capped at maximum.
        do_reset();
        repeat (60) step(1, 1, 1, 0);

        // Reset asserted in the middle of country green.
        for (int i = 0; i < 200 && !(m_ph == 3 && m_t == 5); i++) step(1, 1, 1, 0);
        check("reach_cg_mid", m_ph * 100 + m_t, 305);
        do_reset();

        // Single-cycle pulse is latched; CG runs only the minimum.
        repeat (5) step(1, 1, 0, 0);
        step(1, 1, 1, 0);
        repeat (40) step(1, 1, 0, 0);

        // Demand drops during CG cycle 7: CG length 8.
        do_reset();
        for (int i = 0; i < 200 && !(m_ph == 3 && m_t == 7); i++) step(1, 1, 1, 0);
        check("reach_cg7", m_ph * 100 + m_t, 307);
        repeat (20) step(1, 1, 0, 0);

        // Freeze in HY cycle 2, then resume.
        do_reset();
        for (int i = 0; i < 200 && !(m_ph == 1 && m_t == 2); i++) step(1, 1, 1, 0);
        check("reach_hy2", m_ph * 100 + m_t, 102);
        repeat (10) step(1, 0, 1, 0);
        repeat (30) step(1, 1, 0, 0);

`ifdef PED_XING_EN
        // Pedestrian request alone forces a full-length walk green.
        do_reset();
        repeat (3) step(1, 1, 0, 0);
        step(1, 1, 0, 1);
        repeat (60) step(1, 1, 0, 0);
`endif

        // Randomized traffic, enables, pedestrian pulses and occasional resets.
        xr = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) xr = ~xr;
            step($urandom_range(0, 499) != 0, $urandom_range(0, 7) != 0, xr,
                 $urandom_range(0, 29) == 0);
        end

        repeat (3) @(negedge clk);
        check("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
